// File: rtl/fifo_wr_source.sv
// fifo_wr_source: write-side producer for the async FIFO (skid buffer, level tracking, frame stats).
// Optional macro FRAME_GATE_EN: hold a frame at its start until the FIFO can take MAX_FRAME beats.
module fifo_wr_source #(
    parameter int ADDRSIZE  = 4,
    parameter int DSIZE     = 8,
    parameter int AF_THRESH = 12,
    parameter int MAX_FRAME = 8
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                s_valid,
    input  logic [DSIZE-1:0]    s_data,
    input  logic                s_last,
    output logic                s_ready,
    output logic                winc,
    output logic [DSIZE-1:0]    wdata,
    input  logic                wfull,
    input  logic [ADDRSIZE:0]   wd_rptr,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                walmost_full,
    output logic [15:0]         frame_cnt,
    output logic                err_long
);
    localparam int PW = ADDRSIZE + 1;
    localparam int LW = ADDRSIZE + 2;
    localparam int BW = $clog2(MAX_FRAME + 1);
    typedef enum logic [1:0] {IDLE, STREAM, GATE} state_t;

    state_t            state, state_n;
    logic [1:0]        cnt, cnt_n;
    logic [DSIZE-1:0]  d0, d1;
    logic              l0, l1;
    logic              accept, ready_allow;
    logic [PW-1:0]     wcount, rbin, level_n;
    logic [BW-1:0]     beat_cnt;

    assign accept  = s_valid & s_ready;
    assign winc    = (cnt != 2'd0) & ~wfull;
    assign wdata   = d0;
    assign level_n = wcount - rbin;
    assign cnt_n   = cnt + {1'b0, accept} - {1'b0, winc};

    for (genvar i = 0; i < PW; i++) begin : g_gray
        assign rbin[i] = ^(wd_rptr >> i);
    end

`ifdef FRAME_GATE_EN
    logic room_ok;
    assign room_ok = LW'(wlevel) + LW'(cnt) + LW'(MAX_FRAME) <= LW'(1 << ADDRSIZE);
`endif

    // skid buffer: d0/l0 is the head feeding the FIFO, d1/l1 absorbs one beat while the head stalls
    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            cnt <= '0;
            d0  <= '0;
            l0  <= 1'b0;
            d1  <= '0;
            l1  <= 1'b0;
        end else begin
            cnt <= cnt_n;
            if (winc && cnt == 2'd2) begin
                d0 <= d1;
                l0 <= l1;
            end else if (accept && (cnt == 2'd0 || winc)) begin
                d0 <= s_data;
                l0 <= s_last;
            end
            if (accept && cnt == 2'd1 && !winc) begin
                d1 <= s_data;
                l1 <= s_last;
            end
        end
    end

    // registered ready: room for a beat next cycle, never letting the second entry overflow
    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) s_ready <= 1'b0;
        else       s_ready <= ready_allow & ((cnt_n == 2'd0) | ((cnt_n == 2'd1) & ~wfull));
    end

    // commit count, occupancy estimate across pointer wrap, and committed-frame statistics
    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            wcount       <= '0;
            wlevel       <= '0;
            walmost_full <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            wlevel       <= level_n;
            walmost_full <= level_n >= PW'(AF_THRESH);
            if (winc) begin
                wcount <= wcount + 1'b1;
                if (l0) frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // frame length: beat_cnt holds beats already accepted in the open frame, saturating at MAX_FRAME
    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            beat_cnt <= '0;
            err_long <= 1'b0;
        end else if (accept) begin
            beat_cnt <= s_last ? '0 : (beat_cnt == BW'(MAX_FRAME) ? beat_cnt : beat_cnt + 1'b1);
            if (beat_cnt == BW'(MAX_FRAME)) err_long <= 1'b1;
        end
    end

    // frame FSM state register
    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) state <= IDLE;
        else       state <= state_n;
    end

    // frame FSM next state
    always_comb begin
        state_n = state;
        case (state)
`ifdef FRAME_GATE_EN
            IDLE:    if (s_valid) state_n = GATE;
            GATE:    if (room_ok) state_n = STREAM;
`else
            IDLE:    if (accept && !s_last) state_n = STREAM;
`endif
            STREAM:  if (accept && s_last) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // frame FSM output: whether upstream may be offered a beat next cycle
    always_comb begin
`ifdef FRAME_GATE_EN
        ready_allow = (state_n == STREAM);
`else
        ready_allow = 1'b1;
`endif
    end
endmodule

// File: doc/fifo_wr_source.md
Name: fifo_wr_source

Overview:
- Write-side producer for the async FIFO: takes an upstream valid/ready stream and drives the FIFO write port (winc/wdata), honouring wfull.
- Runs entirely in the write clock domain.
- Keeps its own binary count of committed writes and converts the synchronized gray read pointer to binary, giving fill level and almost-full.
- Tracks frames (s_last) for statistics, over-length detection and optional space gating.

Parameters:
- ADDRSIZE, 4, FIFO address width; depth = 2^ADDRSIZE; pointers are ADDRSIZE+1 bits.
- DSIZE, 8, data width.
- AF_THRESH, 12, level at or above which walmost_full asserts (1..2^ADDRSIZE).
- MAX_FRAME, 8, maximum legal beats per frame (1..2^ADDRSIZE).

Ports:
- wclk  in  1  write-domain clock.
- wrst  in  1  asynchronous, active-low reset.
- s_valid  in  1  upstream beat valid.
- s_data  in  DSIZE  upstream beat data.
- s_last  in  1  final beat of frame.
- s_ready  out  1  upstream may transfer.
- winc  out  1  FIFO write strobe.
- wdata  out  DSIZE  FIFO write data.
- wfull  in  1  FIFO full (write domain).
- wd_rptr  in  ADDRSIZE+1  gray read pointer already synchronized to wclk.
- wlevel  out  ADDRSIZE+1  registered FIFO occupancy estimate.
- walmost_full  out  1  registered, wlevel >= AF_THRESH.
- frame_cnt  out  16  completed frames written to FIFO, wraps.
- err_long  out  1  sticky: frame exceeded MAX_FRAME beats.

Behaviour:
- Reset (wrst=0, async): skid buffer empty, s_ready=0, winc=0, wdata=0, wcount=0, wlevel=0, walmost_full=0, frame_cnt=0, err_long=0, FSM=IDLE.
- s_ready rises on the first wclk edge after reset release.
- Upstream transfer: a beat moves when s_valid & s_ready at a wclk edge.
- s_ready is registered; it is 1 when the skid buffer holds 0 entries, or holds 1 entry and the head is not stalled.
- Skid buffer: 2 entries of {data, last}. The head entry drives wdata.
- winc = head_valid & ~wfull, combinational. The FIFO captures wdata on the edge where winc=1.
- Latency: a beat accepted at edge N with the buffer empty is on wdata with winc=1 in cycle N+1, if not full.
- Zero bubbles: the block sustains 1 beat/cycle while wfull=0.
- wfull=1: winc=0 and the head is held stable. The second entry fills, then s_ready drops. No beat is dropped or duplicated.
- wcount (ADDRSIZE+1 bits) increments by 1 on every edge with winc=1. It wraps modulo 2^(ADDRSIZE+1).
- rbin = gray-to-binary of wd_rptr, with rbin[i] = XOR of wd_rptr[ADDRSIZE:i].
- wlevel <= (wcount - rbin) mod 2^(ADDRSIZE+1), registered each cycle. Legal range is 0..2^ADDRSIZE.
- Pointer wrap: the modular subtraction gives the correct level across wrap in both counters.
- walmost_full <= (next wlevel >= AF_THRESH), same cycle as wlevel.
- FSM states:
  - IDLE: no frame open. Accepting a beat with s_last=0 moves to STREAM. A beat with s_last=1 is a single-beat frame; stay in IDLE.
  - STREAM: frame open; beat counter counts accepted beats. The beat with s_last=1 returns to IDLE and clears the counter.
  - GATE: only when FRAME_GATE_EN is defined (see below).
- Over-length: accepting beat number MAX_FRAME+1 of a frame sets err_long. err_long stays 1 until reset. The frame is still passed through unchanged.
- frame_cnt increments when winc=1 and the head entry has last=1, i.e. on FIFO commit, not on upstream accept.
- Simultaneous accept and commit in one cycle: both happen; the buffer count is unchanged.
- Reset mid-frame: everything returns to reset values immediately. Buffered beats are discarded, and the FIFO write side is reset by the same wrst.

Optional Feature:
- Macro FRAME_GATE_EN.
- Defined:
  - In IDLE with s_valid=1, the FSM enters GATE and holds s_ready=0 until free space is sufficient.
  - Free space is (2^ADDRSIZE - wlevel - buffered entries), and must be >= MAX_FRAME.
  - When sufficient, the FSM moves to STREAM with s_ready=1 on the next cycle.
  - Result: a complete frame of up to MAX_FRAME beats never stalls on wfull mid-frame.
- Not defined: no GATE state. Frames start as soon as buffer space exists; wfull can stall mid-frame.

Test Plan:
- Streaming: ADDRSIZE=4, wd_rptr held 0, s_valid=1, 10 beats data 0x01..0x0A -> winc on 10 consecutive cycles starting 1 cycle after first accept, wdata 0x01..0x0A in order, wlevel reaches 10, walmost_full=0.
- Full stall: continue to 16 writes -> wfull=1 driven, winc=0, wdata held, s_ready=0 after 2 more accepts; release wfull -> the 2 held beats are written in order, none lost.
- Level and wrap: wd_rptr stepped in gray through 0x18 (bin 16) with wcount=0x1C -> wlevel=12, walmost_full=1. wcount wrapped to 0x02 with rbin=0x1E -> wlevel=4.
- Frames: 3 frames of 4 beats, s_last on each 4th beat -> frame_cnt=3, with each increment on the commit edge of the last beat. A 9-beat frame with MAX_FRAME=8 -> err_long=1 on the 9th accept and stays set.
- Reset: wrst pulsed low mid-frame with 2 entries buffered -> winc=0, wlevel=0, frame_cnt=0, s_ready=0 immediately; s_ready=1 one edge after release.
- FRAME_GATE_EN: wlevel=10 and s_valid=1 in IDLE -> s_ready=0 (free 6 < 8); rbin advances so wlevel=8 -> s_ready=1 the following cycle and the frame flows without wfull stall.
